// File: rtl/core_pkg.sv
// Shared constants and types for the core's fixed-latency memory port.
// Holds the MMIO register offsets and the read-source select used by mem_responder.
package core_pkg;

   localparam logic [31:0] MMIO_CYCLE_OFS  = 32'h0000_0000;
   localparam logic [31:0] MMIO_TX_OFS     = 32'h0000_0004;
   localparam logic [31:0] MMIO_STATUS_OFS = 32'h0000_0008;
   localparam int          MEM_RD_LATENCY  = 2;

   typedef enum logic [1:0] {
      SEL_RAM    = 2'd0,
      SEL_CYCLE  = 2'd1,
      SEL_STATUS = 2'd2,
      SEL_ZERO   = 2'd3
   } rdsel_t;

endpackage

// File: rtl/mem_responder_bram.sv
// Single-port word RAM with a registered, read-first output.
// The output register has a synchronous reset so a flushed pipeline reads back zero.
module bram_sp #(
   parameter int ADDR_W    = 14,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] idx,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       q
);

   logic [31:0] mem_r [0:(2**ADDR_W)-1];
   logic [31:0] q_r;

   // Array write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[idx] <= wdata;
      end
   end

   // Registered read; sees the pre-write contents on a same-cycle write
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_r <= 32'h0000_0000;
      end else begin
         q_r <= mem_r[idx];
      end
   end

   assign q = q_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: block RAM plus cycle counter, 1-entry TX buffer and status MMIO.
// Reads return two cycles after addr is presented, one new address accepted every cycle.
module mem_responder
   import core_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter              INIT_FILE = "",
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        err
);

   logic [31:0] addr_al_s;
   logic [31:0] ofs_s;
   logic        is_mmio_s;
   logic        misalign_s;
   logic        ram_we_s;
   logic        tx_wr_s;
   logic        st_wr_s;
   rdsel_t      rdsel_s;
   logic [31:0] ram_q_s;
   logic [31:0] status_s;
   logic [31:0] rd_mux_s;

   logic [31:0] cnt_r;
   rdsel_t      rdsel_r;
   logic [31:0] rdata_r;
   logic [7:0]  tx_data_r;
   logic        tx_valid_r;
   logic        ovf_r;
   logic        err_r;

   assign addr_al_s  = {addr[31:2], 2'b00};
   assign is_mmio_s  = (addr >= MMIO_BASE);
   assign misalign_s = (addr[1:0] != 2'b00);
   assign ofs_s      = addr_al_s - MMIO_BASE;
   assign status_s   = {29'd0, err_r, ovf_r, tx_valid_r};

   // Address decode: write strobes per target and the read source for this address
   always_comb begin
      ram_we_s = 1'b0;
      tx_wr_s  = 1'b0;
      st_wr_s  = 1'b0;
      rdsel_s  = SEL_RAM;
      if (is_mmio_s) begin
         case (ofs_s)
            MMIO_CYCLE_OFS:  rdsel_s = SEL_CYCLE;
            MMIO_STATUS_OFS: rdsel_s = SEL_STATUS;
            default:         rdsel_s = SEL_ZERO;
         endcase
         if (we && !misalign_s) begin
            tx_wr_s = (ofs_s == MMIO_TX_OFS);
            st_wr_s = (ofs_s == MMIO_STATUS_OFS);
         end else begin
            tx_wr_s = 1'b0;
            st_wr_s = 1'b0;
         end
      end else begin
         rdsel_s  = SEL_RAM;
         ram_we_s = we && !misalign_s;
      end
   end

   bram_sp #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_bram (
      .clk   (clk),
      .rstn  (rstn),
      .idx   (addr[ADDR_W+1:2]),
      .we    (ram_we_s),
      .wdata (wdata),
      .q     (ram_q_s)
   );

   // Stage-2 source mux; CYCLE reports the count as of the cycle rdata becomes visible
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (rdsel_r)
         SEL_RAM:    rd_mux_s = ram_q_s;
         SEL_CYCLE:  rd_mux_s = cnt_r + 32'd1;
         SEL_STATUS: rd_mux_s = status_s;
         SEL_ZERO:   rd_mux_s = 32'h0000_0000;
         default:    rd_mux_s = 32'h0000_0000;
      endcase
   end

   // Read pipeline and free-running cycle counter
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rdsel_r <= SEL_RAM;
         rdata_r <= 32'h0000_0000;
         cnt_r   <= 32'h0000_0000;
      end else begin
         rdsel_r <= rdsel_s;
         rdata_r <= rd_mux_s;
         cnt_r   <= cnt_r + 32'd1;
      end
   end

   // TX buffer: a write is accepted if the slot is empty or drains this same cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
      end else if (tx_wr_s && (!tx_valid_r || tx_ready)) begin
         tx_data_r  <= wdata[7:0];
         tx_valid_r <= 1'b1;
      end else if (tx_valid_r && tx_ready) begin
         tx_valid_r <= 1'b0;
      end else begin
         tx_valid_r <= tx_valid_r;
      end
   end

   // Sticky status flags; a set in the same cycle as a write-1-to-clear wins
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ovf_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         ovf_r <= (tx_wr_s && tx_valid_r && !tx_ready) ||
                  (ovf_r && !(st_wr_s && wdata[1]));
         err_r <= (we && misalign_s) ||
                  (err_r && !(st_wr_s && wdata[2]));
      end
   end

   assign rdata    = rdata_r;
   assign tx_data  = tx_data_r;
   assign tx_valid = tx_valid_r;
   assign err      = err_r;

endmodule
